// File: rtl/add32_seq_ctrl.sv
// Sequential WIDTH-bit add/subtract: one SLICE-bit ripple slice per clock, with the carry registered between slices.
// Latency is N = WIDTH/SLICE cycles from the accepting edge to done. start is honoured only in IDLE and is never queued.
module add32_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  op_a, op_b, acc, acc_nxt;
    logic [SLICE-1:0]  a_sl, b_sl, slice_sum;
    logic              slice_co;
    logic              last;
    logic              ovf_nxt;
    int                base;

    // Shared slice adder plus the accumulator image with the current slice merged in.
    always_comb begin
        base      = int'(idx) * SLICE;
        a_sl      = op_a[base +: SLICE];
        b_sl      = op_b[base +: SLICE];
        {slice_co, slice_sum} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
        acc_nxt   = acc;
        acc_nxt[base +: SLICE] = slice_sum;
        last      = (idx == LAST);
        // op_b already holds ~b for subtract, so one overflow rule covers both.
        ovf_nxt   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (acc_nxt[WIDTH-1] != op_a[WIDTH-1]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub | cin;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    carry <= slice_co;
                    idx   <= last ? '0 : idx + IDXW'(1);
                    if (last) begin
                        sum  <= acc_nxt;
                        cout <= slice_co;
                        ovf  <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/add32_seq_ctrl.md
# add32_seq_ctrl

Multi-cycle sequencer that computes a WIDTH-bit add or subtract by reusing one SLICE-bit ripple-carry slice, one slice per clock. Carry is registered between slices. It trades latency for area, replacing a full-width ripple chain in area-constrained paths. It accepts one operation per start/done handshake and sits between a requesting control unit and the shared slice adder it owns.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE
- SLICE, 8, width of the internal ripple-carry slice; N = WIDTH/SLICE slice steps per operation
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  operation request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1); captured on the accepting edge
- busy  output  1  high from the cycle after acceptance through the done cycle
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  result; held from done until the next done
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

## Operation
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- States:
  - IDLE: waiting for start.
  - RUN: slice steps, with a slice index idx from 0 to N-1.
  - DONE: one cycle.
- IDLE→RUN on an edge with start=1. On that edge:
  - capture opA=a;
  - capture opB = sub ? ~b : b;
  - carry = sub ? 1 : cin;
  - idx=0.
- Each RUN edge:
  - the slice computes opA[idx] + opB[idx] + carry;
  - the slice sum is written to accumulator slice idx;
  - carry ← slice carry-out;
  - idx increments.
- When the idx=N-1 step is written, the state goes RUN→DONE. On that same edge:
  - sum ← full accumulator (including the final slice);
  - cout ← final carry;
  - ovf ← (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]).
- DONE→IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. It is not queued, and there is no back-to-back acceptance from DONE.
- Operand inputs may change freely after the accepting edge. Only the captured copies are used.
- sum, cout and ovf change only on the edge entering DONE. They are stable at all other times, including during RUN of the next operation.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, idx=0, carry=0, accumulator=0;
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - The in-flight operation is discarded. No done is produced for it.
- Reset release: the first edge with rst_n=1 may accept start.

## Timing
- Accepting edge E0. RUN occupies edges E1..EN. done=1 in the cycle following EN. busy=1 from after E0 through the done cycle.
- Latency: start accepted to done asserted = N cycles (4 for the defaults).
- Minimum start-to-start spacing: N+2 cycles. Edge E(N+1) returns to IDLE, so start is first accepted at E(N+2).
- done is exactly one cycle wide and coincident with the final busy cycle.
- All outputs are registered. There are no combinational input→output paths.

## Test plan
- **Add wrap:** a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 → sum=0x00000000, cout=1, ovf=0. done high exactly 4 cycles after the accepting edge, and busy high for 5 cycles.
- **Signed overflow:** a=0x7FFFFFFF, b=0x00000001, sub=0 → sum=0x80000000, cout=0, ovf=1.
- **Carry across slice boundary:** a=0x000000FF, b=0x00000000, cin=1, sub=0 → sum=0x00000100, cout=0, ovf=0.
- **Subtract with borrow:** a=5, b=7, sub=1, cin=1 (must be ignored) → sum=0xFFFFFFFE, cout=0, ovf=0.
- **Subtract with no borrow:** a=7, b=5, sub=1 → sum=2, cout=1.
- **Ignored request:** pulse start with different operands during RUN and during DONE → the first result is unchanged, no second done appears, and the next start in IDLE is accepted normally.
- **Reset mid-operation:** assert rst_n=0 after two RUN edges → all outputs 0 immediately (asynchronously), state IDLE, no done. After release, a=3, b=4 add → sum=7, done 4 cycles after acceptance.
